// File: rtl/brew_countdown_timer_pkg.sv
// brew_countdown_timer_pkg
//   Shared definitions for the brew countdown timer and the seven-segment
//   driver downstream: FSM state encodings, BCD digit width, the nibble
//   order of the 16-bit digit bus and the preset clamp helper.
package brew_countdown_timer_pkg;

  localparam int BCD_W = 4;

  // Nibble index within the {min_tens,min_ones,sec_tens,sec_ones} bus.
  localparam int DIG_SEC_ONES = 0;
  localparam int DIG_SEC_TENS = 1;
  localparam int DIG_MIN_ONES = 2;
  localparam int DIG_MIN_TENS = 3;
  localparam int NUM_DIGITS   = 4;

  typedef enum logic [1:0] {
    TIMER_ST_IDLE  = 2'd0,
    TIMER_ST_RUN   = 2'd1,
    TIMER_ST_PAUSE = 2'd2,
    TIMER_ST_DONE  = 2'd3
  } timer_st_t;

  // Largest legal value of a digit, which is also its wrap value on borrow.
  function automatic logic [BCD_W-1:0] digit_max(input int idx);
    return (idx == DIG_SEC_TENS) ? BCD_W'(5) : BCD_W'(9);
  endfunction

  // Saturate each nibble to its legal maximum, so the count never exceeds 99:59.
  function automatic logic [NUM_DIGITS*BCD_W-1:0] clamp_preset(
    input logic [NUM_DIGITS*BCD_W-1:0] preset
  );
    logic [NUM_DIGITS*BCD_W-1:0] res;
    logic [BCD_W-1:0]            nib;
    res = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = preset[i*BCD_W +: BCD_W];
      if (nib > digit_max(i)) nib = digit_max(i);
      res[i*BCD_W +: BCD_W] = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/brew_countdown_timer_bcd_digit_down.sv
// bcd_digit_down
//   One BCD down-counting digit. Loads ld_val on ld, otherwise steps down by
//   one on dec, wrapping 0 -> modulus_max and flagging borrow_out so the next
//   digit up the chain decrements on the same edge.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset (q -> 0)
//   ld, ld_val   synchronous load (priority over dec)
//   dec          decrement enable
//   modulus_max  wrap value (9 or 5)
//   q            current digit
//   borrow_out   dec while q==0 (combinational, feeds next digit's dec)
module bcd_digit_down
  import brew_countdown_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             dec,
  input  logic [BCD_W-1:0] modulus_max,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  assign borrow_out = dec && (q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (dec) begin
      q <= (q == '0) ? modulus_max : q - BCD_W'(1);
    end
  end

endmodule

// File: rtl/brew_countdown_timer.sv
// brew_countdown_timer
//   MM:SS brew countdown. Holds four BCD digits, decrements once per
//   TICK_DIV clocks while running and pulses done on reaching 00:00.
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   load        strobe: capture clamped preset_bcd, return to IDLE
//   preset_bcd  {min_tens,min_ones,sec_tens,sec_ones}
//   start       strobe: begin / resume counting
//   pause       strobe: freeze count
//   digits      current count, same nibble order as preset_bcd
//   running     1 while in RUN
//   done        1-cycle pulse on reaching 00:00
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | prescaler counting, digits decrement on each tick
// PAUSE | count and prescaler frozen, start resumes
// DONE  | reached 00:00, only load leaves
module brew_countdown_timer
  import brew_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int PRESC_W  = 26
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [NUM_DIGITS*BCD_W-1:0] preset_bcd,
  input  logic                        start,
  input  logic                        pause,
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic                        running,
  output logic                        done
);

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICK_DIV - 1);
  localparam logic [NUM_DIGITS*BCD_W-1:0] ONE_SEC = (NUM_DIGITS*BCD_W)'(1);

  timer_st_t          state;
  logic [PRESC_W-1:0] presc;

  logic [NUM_DIGITS*BCD_W-1:0] ld_val;
  logic [NUM_DIGITS-1:0]       dig_dec;
  logic [NUM_DIGITS-1:0]       dig_borrow;
  logic                        tick;
  logic                        digits_zero;

  assign ld_val      = clamp_preset(preset_bcd);
  assign digits_zero = (digits == '0);

  // load and pause both pre-empt the tick, so a pause on the terminal
  // prescaler cycle freezes the count without stepping it.
  assign tick = (state == TIMER_ST_RUN) && !load && !pause && (presc == PRESC_TC);

  assign dig_dec[DIG_SEC_ONES] = tick && !digits_zero;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign dig_dec[i] = dig_borrow[i-1];
    end

    bcd_digit_down u_digit (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld          (load),
      .ld_val      (ld_val[i*BCD_W +: BCD_W]),
      .dec         (dig_dec[i]),
      .modulus_max (digit_max(i)),
      .q           (digits[i*BCD_W +: BCD_W]),
      .borrow_out  (dig_borrow[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TIMER_ST_IDLE;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= TIMER_ST_IDLE;
        presc   <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          TIMER_ST_IDLE: begin
            if (start && !pause) begin
              if (digits_zero) begin
                state <= TIMER_ST_DONE;
                done  <= 1'b1;
              end else begin
                state   <= TIMER_ST_RUN;
                running <= 1'b1;
              end
            end
          end
          TIMER_ST_RUN: begin
            if (pause) begin
              state   <= TIMER_ST_PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              presc <= '0;
              // Only 00:01 steps to 00:00 on a tick.
              if (digits == ONE_SEC) begin
                state   <= TIMER_ST_DONE;
                running <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
          TIMER_ST_PAUSE: begin
            if (start && !pause && !digits_zero) begin
              state   <= TIMER_ST_RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brew_countdown_timer.sv
module tb_brew_countdown_timer;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] preset_bcd;
  logic        start;
  logic        pause;
  logic [15:0] digits;
  logic        running;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  brew_countdown_timer #(
    .TICK_DIV (4),
    .PRESC_W  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .preset_bcd (preset_bcd),
    .start      (start),
    .pause      (pause),
    .digits     (digits),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one active edge, then settle 1 time unit past it.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] val);
    preset_bcd = val;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; preset_bcd = 16'h0000;
    #12;
    check_val("reset_digits",  digits, 16'h0000);
    check_val("reset_running", {15'd0, running}, 16'd0);
    check_val("reset_done",    {15'd0, done}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();

    // 00:12 basic countdown and latency
    do_load(16'h0012);
    check_val("ld12_digits",  digits, 16'h0012);
    check_val("ld12_running", {15'd0, running}, 16'd0);
    do_start();
    check_val("st12_running", {15'd0, running}, 16'd1);
    cyc(3);
    check_val("st12_3clk", digits, 16'h0012);
    cyc();
    check_val("st12_4clk", digits, 16'h0011);
    cyc(4);
    check_val("st12_8clk", digits, 16'h0010);

    // asynchronous reset mid-run
    cyc();
    rst_n = 1'b0;
    #1;
    check_val("arst_digits",  digits, 16'h0000);
    check_val("arst_running", {15'd0, running}, 16'd0);
    check_val("arst_done",    {15'd0, done}, 16'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // borrow across sec_tens and min_ones
    do_load(16'h0100);
    do_start();
    cyc(4);
    check_val("borrow_0059", digits, 16'h0059);

    // borrow through all three lower digits
    do_load(16'h1000);
    do_start();
    cyc(4);
    check_val("borrow_0959", digits, 16'h0959);

    // terminal count
    do_load(16'h0002);
    do_start();
    cyc(4);
    check_val("tc_0001",      digits, 16'h0001);
    check_val("tc_done_early", {15'd0, done}, 16'd0);
    cyc(4);
    check_val("tc_0000",      digits, 16'h0000);
    check_val("tc_done_pulse", {15'd0, done}, 16'd1);
    check_val("tc_running",   {15'd0, running}, 16'd0);
    cyc();
    check_val("tc_done_clear", {15'd0, done}, 16'd0);
    do_start();
    check_val("done_st_running", {15'd0, running}, 16'd0);
    check_val("done_st_done",    {15'd0, done}, 16'd0);
    cyc(5);
    check_val("done_hold", digits, 16'h0000);

    // start from IDLE at 00:00 goes straight to DONE
    do_load(16'h0000);
    do_start();
    check_val("zst_done",    {15'd0, done}, 16'd1);
    check_val("zst_running", {15'd0, running}, 16'd0);
    cyc();
    check_val("zst_done_clr", {15'd0, done}, 16'd0);

    // pause after two RUN clocks, hold, resume
    do_load(16'h0030);
    do_start();
    cyc(2);
    do_pause();
    check_val("pause_running", {15'd0, running}, 16'd0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      check_val("pause_hold", digits, 16'h0030);
    end
    do_start();
    check_val("resume_running", {15'd0, running}, 16'd1);
    cyc();
    check_val("resume_1clk", digits, 16'h0030);
    cyc();
    check_val("resume_2clk", digits, 16'h0029);

    // clamp and load priority
    do_load(16'hFA7C);
    check_val("clamp_9959", digits, 16'h9959);
    do_start();
    cyc(4);
    check_val("max_dec_9958", digits, 16'h9958);
    preset_bcd = 16'h0005;
    load  = 1'b1;
    start = 1'b1;
    cyc();
    load  = 1'b0;
    start = 1'b0;
    check_val("ldst_digits",  digits, 16'h0005);
    check_val("ldst_running", {15'd0, running}, 16'd0);
    cyc(4);
    check_val("ldst_idle_hold", digits, 16'h0005);
    check_val("ldst_running2",  {15'd0, running}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
